// File: rtl/inert_spi_resp.sv
// SPI responder modelling the inertial sensor's register map: 16-bit frames,
// config registers, yaw-rate output bytes with a coherent high-byte shadow, and INT.
module inert_spi_resp #(
    parameter logic [7:0] WHO_AM_I = 8'h6A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic [15:0] yaw_in,
    input  logic        sample_vld,
    output logic        frame_err,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  ss_q, sclk_q;
    logic [1:0]  mosi_q;
    logic [4:0]  cnt;
    logic [15:0] shreg;
    logic [7:0]  tx;
    logic        tx_active;
    logic [7:0]  int1_ctrl, ctrl2_g, ctrl5;
    logic [15:0] outz;
    logic [7:0]  shadow;
    logic [7:0]  read_byte;

    // Bit 2 of each sync chain is the delayed copy used only for edge detection.
    wire        ss_fall   = ss_q[2] & ~ss_q[1];
    wire        ss_rise   = ~ss_q[2] & ss_q[1];
    wire        sclk_rise = ~sclk_q[2] & sclk_q[1];
    wire        sclk_fall = sclk_q[2] & ~sclk_q[1];
    wire [15:0] shift_in  = {shreg[14:0], mosi_q[1]};
    wire [6:0]  rd_addr   = shift_in[6:0];
    wire        frame_ok  = (cnt == 5'd16);
    wire        commit    = (state_q == COMMIT);
    wire        wr_commit = commit & frame_ok & ~shreg[15];
    wire        int_clr   = commit & frame_ok & shreg[15] & (shreg[14:8] == 7'h27);
    wire        capture   = sample_vld & (ctrl2_g != 8'h00);

    assign MISO      = tx_active & tx[7];
    assign fsm_state = state_q;

    always_comb begin
        read_byte = 8'h00;
        case (rd_addr)
            7'h0D:   read_byte = int1_ctrl;
            7'h0F:   read_byte = WHO_AM_I;
            7'h11:   read_byte = ctrl2_g;
            7'h14:   read_byte = ctrl5;
            7'h26:   read_byte = outz[7:0];
            7'h27:   read_byte = shadow;
            default: read_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall) state_d = SHIFT;
            SHIFT:   if (ss_rise) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_q      <= 3'b111;
            sclk_q    <= 3'b111;
            mosi_q    <= 2'b00;
            cnt       <= 5'd0;
            shreg     <= 16'h0000;
            tx        <= 8'h00;
            tx_active <= 1'b0;
            int1_ctrl <= 8'h00;
            ctrl2_g   <= 8'h00;
            ctrl5     <= 8'h00;
            outz      <= 16'h0000;
            shadow    <= 8'h00;
            INT       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ss_q      <= {ss_q[1:0], SS_n};
            sclk_q    <= {sclk_q[1:0], SCLK};
            mosi_q    <= {mosi_q[0], MOSI};
            frame_err <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (ss_fall) begin
                        cnt       <= 5'd0;
                        shreg     <= 16'h0000;
                        tx        <= 8'h00;
                        tx_active <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        tx_active <= 1'b0;
                    end else if (sclk_rise) begin
                        shreg <= shift_in;
                        if (cnt != 5'd31) cnt <= cnt + 5'd1;
                        // Rise 8 completes R/W + address; the shadow snapshot rides on the low-byte load.
                        if (cnt == 5'd7 && shreg[6]) begin
                            tx        <= read_byte;
                            tx_active <= 1'b1;
                            if (rd_addr == 7'h26) shadow <= outz[15:8];
                        end
                    end else if (sclk_fall && cnt >= 5'd9 && cnt <= 5'd15) begin
                        tx <= {tx[6:0], 1'b0};
                    end
                end
                COMMIT: begin
                    frame_err <= ~frame_ok;
                    if (wr_commit) begin
                        case (shreg[14:8])
                            7'h0D:   int1_ctrl <= shreg[7:0];
                            7'h11:   ctrl2_g   <= shreg[7:0];
                            7'h14:   ctrl5     <= shreg[7:0];
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase

            if (capture) outz <= yaw_in;
            // A new sample outranks a clearing read in the same cycle.
            if (capture && int1_ctrl[1]) INT <= 1'b1;
            else if (int_clr)            INT <= 1'b0;
        end
    end

endmodule
